// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 4-digit 7-segment scan logic.
// Segment patterns are active-high {g,f,e,d,c,b,a}; digit selects are one-hot, digit 0 = leftmost select bit.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    LIT,
    DARK
  } scan_state_t;

  // Index 0 is the rightmost digit, which is wired to cc[3].
  localparam logic [3:0][3:0] CC_ONEHOT = {4'b0001, 4'b0010, 4'b0100, 4'b1000};

  // Hex glyphs, entry 15 first: F E d C b A 9 8 7 6 5 4 3 2 1 0.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [3:0] cc_onehot(input logic [1:0] idx);
    return CC_ONEHOT[idx];
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Hex digit plus decimal point to active-high {dp,g..a} segment lines.
// Purely combinational, zero latency, no flow control.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] value,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {dp, SEG_HEX[value]};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler: double-buffered digits, blank/lit/dark slot timing, frame-aligned commit.
// cc/seg_out registered (1 cycle after state); writes stall via wr_ready while a commit is pending.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 250000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       disp_en,
  input  logic [3:0] bright,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic       upd_req,
  output logic       upd_pending,
  output logic       frame_done,
  output logic [3:0] cc,
  output logic [7:0] seg_out
);

  localparam int STEP  = (SCAN_DIV - BLANK_CYC) / 16;
  localparam int CNT_W = $clog2(SCAN_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_W    = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0] STEP_W     = CNT_W'(STEP);

  scan_state_t      state, state_nxt;
  logic [CNT_W-1:0] slot_cnt, slot_nxt;
  logic [1:0]       dig_idx, dig_nxt;
  logic [3:0]       bright_q, bright_nxt, bright_eff;
  logic [CNT_W-1:0] lit_last;
  logic             slot_end;

  logic [3:0][4:0]  staging;
  logic [3:0][4:0]  display;
  logic [4:0]       cur_digit;
  logic [7:0]       dec_seg;
  logic [3:0]       cc_d;
  logic [7:0]       seg_d;

  assign slot_end   = (slot_cnt == CNT_LAST);
  assign frame_done = (state != IDLE) && (dig_idx == 2'd3) && slot_end;
  assign wr_ready   = ~upd_pending;
  assign lit_last   = BLANK_W + CNT_W'(bright_q) * STEP_W - CNT_W'(1);
  // With a one-cycle blank the sample cycle is also the decision cycle.
  assign bright_eff = (slot_cnt == '0) ? bright : bright_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= IDLE;
      slot_cnt <= '0;
      dig_idx  <= 2'd0;
      bright_q <= 4'd0;
    end else begin
      state    <= state_nxt;
      slot_cnt <= slot_nxt;
      dig_idx  <= dig_nxt;
      bright_q <= bright_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot_cnt;
    dig_nxt    = dig_idx;
    bright_nxt = bright_q;
    if (!disp_en) begin
      state_nxt = IDLE;
      slot_nxt  = '0;
      dig_nxt   = 2'd0;
    end else if (state == IDLE) begin
      state_nxt = BLANK;
      slot_nxt  = '0;
      dig_nxt   = 2'd0;
    end else if (slot_end) begin
      state_nxt = BLANK;
      slot_nxt  = '0;
      dig_nxt   = dig_idx + 2'd1;
    end else begin
      slot_nxt = slot_cnt + CNT_W'(1);
      case (state)
        BLANK: begin
          if (slot_cnt == '0) bright_nxt = bright;
          if (slot_cnt == BLANK_LAST) state_nxt = (bright_eff != 4'd0) ? LIT : DARK;
        end
        LIT: begin
          if (slot_cnt == lit_last) state_nxt = DARK;
        end
        default: ;
      endcase
    end
  end

  assign cur_digit = display[dig_idx];

  seg_hex_decoder u_dec (
    .value (cur_digit[3:0]),
    .dp    (cur_digit[4]),
    .seg   (dec_seg)
  );

  // Gating with disp_en blanks the pins on the same edge that drops to IDLE.
  always_comb begin
    cc_d  = 4'b0000;
    seg_d = 8'h00;
    if (disp_en && (state == LIT)) begin
      cc_d  = cc_onehot(dig_idx);
      seg_d = dec_seg;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      staging     <= '0;
      display     <= '0;
      upd_pending <= 1'b0;
      cc          <= 4'b0000;
      seg_out     <= 8'h00;
    end else begin
      if (wr_valid && wr_ready) staging[wr_addr] <= {wr_dp, wr_data};
      // A request landing on the commit edge re-arms for the next frame.
      if (frame_done && upd_pending) begin
        display     <= staging;
        upd_pending <= upd_req;
      end else if (upd_req) begin
        upd_pending <= 1'b1;
      end
      cc      <= cc_d;
      seg_out <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=40, BLANK_CYC=8 (STEP=2).
// Outputs are sampled on the falling edge; lit cycles appear one cycle after the LIT state.
module tb_seg_scan_ctrl;

  localparam int SD = 40;
  localparam int BC = 8;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       disp_en = 1'b0;
  logic [3:0] bright = 4'd0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_addr = 2'd0;
  logic [3:0] wr_data = 4'd0;
  logic       wr_dp = 1'b0;
  logic       upd_req = 1'b0;
  logic       upd_pending;
  logic       frame_done;
  logic [3:0] cc;
  logic [7:0] seg_out;

  int total = 0;
  int bad = 0;

  int         lit_n, first_s, odd, nz;
  logic [3:0] ccs;
  logic [7:0] segs;
  logic       p0, ok;

  always #5 clk_in = ~clk_in;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .disp_en     (disp_en),
    .bright      (bright),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_dp       (wr_dp),
    .upd_req     (upd_req),
    .upd_pending (upd_pending),
    .frame_done  (frame_done),
    .cc          (cc),
    .seg_out     (seg_out)
  );

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // Steps until frame_done is seen; nz counts lit cycles not showing "0".
  task automatic wait_frame_done(output logic found, output int nzc);
    found = 1'b0;
    nzc = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (cc !== 4'b0000 && seg_out !== 8'h3F) nzc++;
      if (frame_done === 1'b1) found = 1'b1;
    end
  endtask

  // Observes one full slot starting from the negedge of the previous slot's last cycle.
  task automatic measure_slot(input int chg_at, input logic [3:0] chg_val,
                              output int n, output int first, output logic [3:0] cc_seen,
                              output logic [7:0] seg_seen, output int odd_n, output logic pend0);
    n = 0; first = -1; cc_seen = 4'b0000; seg_seen = 8'h00; odd_n = 0; pend0 = 1'bx;
    for (int s = 0; s < SD; s++) begin
      step();
      if (s == 0) pend0 = upd_pending;
      if (cc !== 4'b0000) begin
        n++;
        if (first < 0) first = s;
        if (n == 1) begin
          cc_seen = cc;
          seg_seen = seg_out;
        end else if (cc !== cc_seen || seg_out !== seg_seen) odd_n++;
        if (s != first + n - 1) odd_n++;
      end else if (seg_out !== 8'h00) odd_n++;
      if (s == chg_at) bright = chg_val;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    disp_en = 1'b0;
    step();
    step();
    total++; if (cc !== 4'b0000) begin bad++; $display("FAIL reset_cc got=%b exp=0000", cc); end
    total++; if (seg_out !== 8'h00) begin bad++; $display("FAIL reset_seg got=%h exp=00", seg_out); end
    total++; if (upd_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0", upd_pending); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
  endtask

  task automatic test_scan_commit();
    logic [3:0] exp_cc [4];
    logic [7:0] exp_seg [4];
    exp_cc = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    exp_seg = '{8'h06, 8'h5B, 8'h4F, 8'h66};
    rst = 1'b0;
    bright = 4'd15;
    disp_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 2'(i); wr_data = 4'(i + 1); wr_dp = 1'b0;
      step();
    end
    wr_valid = 1'b0;
    upd_req = 1'b1;
    step();
    upd_req = 1'b0;
    total++; if (upd_pending !== 1'b1) begin bad++; $display("FAIL req_pending got=%b exp=1", upd_pending); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL req_wr_ready got=%b exp=0", wr_ready); end
    wait_frame_done(ok, nz);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL first_frame_timeout got=%b exp=1", ok); end
    total++; if (nz !== 0) begin bad++; $display("FAIL pre_commit_zero got=%0d exp=0", nz); end
    total++; if (upd_pending !== 1'b1) begin bad++; $display("FAIL pending_at_fd got=%b exp=1", upd_pending); end
    for (int d = 0; d < 4; d++) begin
      measure_slot(-1, 4'd0, lit_n, first_s, ccs, segs, odd, p0);
      if (d == 0) begin
        total++; if (p0 !== 1'b0) begin bad++; $display("FAIL commit_clear got=%b exp=0", p0); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL commit_wr_ready got=%b exp=1", wr_ready); end
      end
      total++; if (lit_n !== 30) begin bad++; $display("FAIL b15_lit_n d=%0d got=%0d exp=30", d, lit_n); end
      total++; if (first_s !== 9) begin bad++; $display("FAIL b15_first d=%0d got=%0d exp=9", d, first_s); end
      total++; if (ccs !== exp_cc[d]) begin bad++; $display("FAIL b15_cc d=%0d got=%b exp=%b", d, ccs, exp_cc[d]); end
      total++; if (segs !== exp_seg[d]) begin bad++; $display("FAIL b15_seg d=%0d got=%h exp=%h", d, segs, exp_seg[d]); end
      total++; if (odd !== 0) begin bad++; $display("FAIL b15_shape d=%0d got=%0d exp=0", d, odd); end
    end
  endtask

  task automatic test_bright();
    bright = 4'd0;
    for (int d = 0; d < 4; d++) begin
      measure_slot(-1, 4'd0, lit_n, first_s, ccs, segs, odd, p0);
      total++; if (lit_n !== 0) begin bad++; $display("FAIL b0_lit_n d=%0d got=%0d exp=0", d, lit_n); end
      total++; if (odd !== 0) begin bad++; $display("FAIL b0_seg_dark d=%0d got=%0d exp=0", d, odd); end
    end
    bright = 4'd1;
    measure_slot(20, 4'd15, lit_n, first_s, ccs, segs, odd, p0);
    total++; if (lit_n !== 2) begin bad++; $display("FAIL b1_lit_n got=%0d exp=2", lit_n); end
    total++; if (first_s !== 9) begin bad++; $display("FAIL b1_first got=%0d exp=9", first_s); end
    total++; if (segs !== 8'h06) begin bad++; $display("FAIL b1_seg got=%h exp=06", segs); end
    measure_slot(-1, 4'd0, lit_n, first_s, ccs, segs, odd, p0);
    total++; if (lit_n !== 30) begin bad++; $display("FAIL bchg_next_lit_n got=%0d exp=30", lit_n); end
    total++; if (ccs !== 4'b0100) begin bad++; $display("FAIL bchg_next_cc got=%b exp=0100", ccs); end
  endtask

  task automatic test_pending();
    upd_req = 1'b1;
    step();
    upd_req = 1'b0;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL pend_wr_ready got=%b exp=0", wr_ready); end
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 4'h9; wr_dp = 1'b1;
    step();
    wr_valid = 1'b0;
    wait_frame_done(ok, nz);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL pend_fd_timeout got=%b exp=1", ok); end
    measure_slot(-1, 4'd0, lit_n, first_s, ccs, segs, odd, p0);
    total++; if (p0 !== 1'b0) begin bad++; $display("FAIL pend_clear got=%b exp=0", p0); end
    total++; if (segs !== 8'h06) begin bad++; $display("FAIL ignored_write got=%h exp=06", segs); end
    upd_req = 1'b1;
    step();
    upd_req = 1'b0;
    wait_frame_done(ok, nz);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rearm_fd_timeout got=%b exp=1", ok); end
    upd_req = 1'b1;
    step();
    upd_req = 1'b0;
    total++; if (upd_pending !== 1'b1) begin bad++; $display("FAIL req_on_fd got=%b exp=1", upd_pending); end
    wait_frame_done(ok, nz);
    total++; if (upd_pending !== 1'b1) begin bad++; $display("FAIL req_on_fd_hold got=%b exp=1", upd_pending); end
    step();
    total++; if (upd_pending !== 1'b0) begin bad++; $display("FAIL req_on_fd_commit got=%b exp=0", upd_pending); end
  endtask

  task automatic test_disable();
    wait_frame_done(ok, nz);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL dis_fd_timeout got=%b exp=1", ok); end
    for (int i = 0; i < 96; i++) step();
    total++; if (cc !== 4'b0010) begin bad++; $display("FAIL dig2_cc got=%b exp=0010", cc); end
    total++; if (seg_out !== 8'h4F) begin bad++; $display("FAIL dig2_seg got=%h exp=4f", seg_out); end
    disp_en = 1'b0;
    step();
    total++; if (cc !== 4'b0000) begin bad++; $display("FAIL dis_cc got=%b exp=0000", cc); end
    total++; if (seg_out !== 8'h00) begin bad++; $display("FAIL dis_seg got=%h exp=00", seg_out); end
    for (int i = 0; i < 3; i++) step();
    total++; if (cc !== 4'b0000 || frame_done !== 1'b0) begin bad++; $display("FAIL dis_hold got=%b/%b exp=0000/0", cc, frame_done); end
    disp_en = 1'b1;
    measure_slot(-1, 4'd0, lit_n, first_s, ccs, segs, odd, p0);
    total++; if (ccs !== 4'b1000) begin bad++; $display("FAIL reen_cc got=%b exp=1000", ccs); end
    total++; if (first_s !== 9 || lit_n !== 30) begin bad++; $display("FAIL reen_timing got=%0d/%0d exp=9/30", first_s, lit_n); end
  endtask

  task automatic test_reset_mid();
    upd_req = 1'b1;
    step();
    upd_req = 1'b0;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < 14; i++) step();
    total++; if (upd_pending !== 1'b1) begin bad++; $display("FAIL glitch_pending got=%b exp=1", upd_pending); end
    total++; if (cc !== 4'b0100) begin bad++; $display("FAIL glitch_cc got=%b exp=0100", cc); end
    rst = 1'b1;
    step();
    total++; if (cc !== 4'b0000) begin bad++; $display("FAIL mid_rst_cc got=%b exp=0000", cc); end
    total++; if (seg_out !== 8'h00) begin bad++; $display("FAIL mid_rst_seg got=%h exp=00", seg_out); end
    total++; if (upd_pending !== 1'b0) begin bad++; $display("FAIL mid_rst_pending got=%b exp=0", upd_pending); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_wr_ready got=%b exp=1", wr_ready); end
    rst = 1'b0;
    measure_slot(-1, 4'd0, lit_n, first_s, ccs, segs, odd, p0);
    total++; if (segs !== 8'h3F) begin bad++; $display("FAIL mid_rst_display got=%h exp=3f", segs); end
    total++; if (ccs !== 4'b1000 || lit_n !== 30) begin bad++; $display("FAIL mid_rst_scan got=%b/%0d exp=1000/30", ccs, lit_n); end
  endtask

  task automatic test_dp();
    wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 4'hF; wr_dp = 1'b1;
    step();
    wr_valid = 1'b0;
    upd_req = 1'b1;
    step();
    upd_req = 1'b0;
    wait_frame_done(ok, nz);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL dp_fd_timeout got=%b exp=1", ok); end
    measure_slot(-1, 4'd0, lit_n, first_s, ccs, segs, odd, p0);
    total++; if (segs !== 8'h3F) begin bad++; $display("FAIL dp_slot0_seg got=%h exp=3f", segs); end
    measure_slot(-1, 4'd0, lit_n, first_s, ccs, segs, odd, p0);
    measure_slot(-1, 4'd0, lit_n, first_s, ccs, segs, odd, p0);
    measure_slot(-1, 4'd0, lit_n, first_s, ccs, segs, odd, p0);
    total++; if (ccs !== 4'b0001) begin bad++; $display("FAIL dp_slot3_cc got=%b exp=0001", ccs); end
    total++; if (segs !== 8'hF1) begin bad++; $display("FAIL dp_slot3_seg got=%h exp=f1", segs); end
    total++; if (odd !== 0) begin bad++; $display("FAIL dp_slot3_shape got=%0d exp=0", odd); end
  endtask

  initial begin
    @(negedge clk_in);
    test_reset();
    test_scan_commit();
    test_bright();
    test_pending();
    test_disable();
    test_reset_mid();
    test_dp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
